// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing monitor: measures line/frame timing of an incoming
// 1-bit-per-colour stream, locks onto a stable format and re-emits active pixels.
module vga_sync_monitor #(
  parameter int H_BITS      = 10,
  parameter int V_BITS      = 10,
  parameter int H_ACTIVE    = 640,
  parameter int H_START     = 144,
  parameter int V_ACTIVE    = 480,
  parameter int V_START     = 35,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic              clk_pix,
  input  logic              rst,
  input  logic              vga_hs,
  input  logic              vga_vs,
  input  logic              vga_r,
  input  logic              vga_g,
  input  logic              vga_b,
  output logic              locked,
  output logic              px_valid,
  output logic [H_BITS-1:0] px_x,
  output logic [V_BITS-1:0] px_y,
  output logic [2:0]        px_rgb,
  output logic              px_sof,
  output logic              px_eol,
  output logic [H_BITS-1:0] h_total,
  output logic [V_BITS-1:0] v_total,
  output logic              sync_err,
  output logic [1:0]        dbg_state
);

  // Output semantics: px_valid is a pure qualifier with no back-pressure;
  // px_x/px_y/px_rgb/px_sof/px_eol are meaningful only while px_valid is high
  // and are driven to zero otherwise.

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_CHECK   = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  localparam logic [H_BITS-1:0] H_ONE   = H_BITS'(1);
  localparam logic [V_BITS-1:0] V_ONE   = V_BITS'(1);
  localparam logic [H_BITS-1:0] H_FIRST = H_BITS'(H_START);
  localparam logic [H_BITS-1:0] H_END   = H_BITS'(H_START + H_ACTIVE);
  localparam logic [H_BITS-1:0] H_LAST  = H_BITS'(H_START + H_ACTIVE - 1);
  localparam logic [V_BITS-1:0] V_FIRST = V_BITS'(V_START);
  localparam logic [V_BITS-1:0] V_END   = V_BITS'(V_START + V_ACTIVE);
  localparam logic [3:0]        LOCK_N  = 4'(LOCK_FRAMES);

  logic s1_hs, s1_vs, s1_r, s1_g, s1_b;
  logic s2_hs, s2_vs, s2_r, s2_g, s2_b;

  logic [H_BITS-1:0] h_cnt;
  logic [V_BITS-1:0] v_cnt;
  logic              vs_pend;

  state_t            state, state_n;
  logic [H_BITS-1:0] h_ref, h_ref_n;
  logic              h_ref_ok, h_ref_ok_n;
  logic [V_BITS-1:0] v_ref, v_ref_n;
  logic              line_bad, line_bad_n;
  logic [3:0]        match_cnt, match_n;
  logic [H_BITS-1:0] h_total_n;
  logic [V_BITS-1:0] v_total_n;
  logic              sync_err_n;

  logic              hs_lead, vs_lead, boundary, h_sat, len_bad, frame_bad;
  logic [H_BITS-1:0] line_len;
  logic [V_BITS-1:0] frame_len;
  logic              in_win, pv;

  always_ff @(posedge clk_pix or negedge rst) begin
    if (!rst) begin
      s1_hs <= 1'b0; s1_vs <= 1'b0; s1_r <= 1'b0; s1_g <= 1'b0; s1_b <= 1'b0;
      s2_hs <= 1'b0; s2_vs <= 1'b0; s2_r <= 1'b0; s2_g <= 1'b0; s2_b <= 1'b0;
    end else begin
      s1_hs <= vga_hs; s1_vs <= vga_vs; s1_r <= vga_r; s1_g <= vga_g; s1_b <= vga_b;
      s2_hs <= s1_hs;  s2_vs <= s1_vs;  s2_r <= s1_r;  s2_g <= s1_g;  s2_b <= s1_b;
    end
  end

  assign hs_lead   = (s1_hs == HS_POL) && (s2_hs != HS_POL);
  assign vs_lead   = (s1_vs == VS_POL) && (s2_vs != VS_POL);
  // A vsync edge earlier in the line is held until the hsync edge that closes it.
  assign boundary  = hs_lead && (vs_pend || vs_lead);
  assign h_sat     = (h_cnt == '1);
  assign line_len  = h_cnt + H_ONE;
  assign frame_len = v_cnt + V_ONE;
  assign len_bad   = hs_lead && h_ref_ok && (line_len != h_ref);
  assign frame_bad = line_bad || len_bad;

  // h_cnt/v_cnt advance in step with s2, so they index the pixel held there.
  always_ff @(posedge clk_pix or negedge rst) begin
    if (!rst) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      vs_pend <= 1'b0;
    end else begin
      if (hs_lead)     h_cnt <= '0;
      else if (!h_sat) h_cnt <= h_cnt + H_ONE;

      if (boundary)                     v_cnt <= '0;
      else if (hs_lead && v_cnt != '1)  v_cnt <= v_cnt + V_ONE;

      if (boundary)     vs_pend <= 1'b0;
      else if (vs_lead) vs_pend <= 1'b1;
    end
  end

  always_comb begin
    state_n    = state;
    h_ref_n    = h_ref;
    h_ref_ok_n = h_ref_ok;
    v_ref_n    = v_ref;
    line_bad_n = line_bad;
    match_n    = match_cnt;
    h_total_n  = h_total;
    v_total_n  = v_total;
    sync_err_n = 1'b0;
    case (state)
      ST_SEARCH: begin
        // A boundary restarts measurement even after a timeout line.
        if (boundary) begin
          state_n    = ST_MEASURE;
          line_bad_n = 1'b0;
          h_ref_ok_n = 1'b0;
        end
      end
      ST_MEASURE: begin
        if (h_sat) begin
          state_n = ST_SEARCH;
        end else if (boundary) begin
          line_bad_n = 1'b0;
          if (h_ref_ok && !frame_bad && h_ref >= H_END && frame_len >= V_END) begin
            v_ref_n = frame_len;
            match_n = 4'd0;
            state_n = ST_CHECK;
          end else begin
            h_ref_ok_n = 1'b0;
          end
        end else if (hs_lead) begin
          if (!h_ref_ok) begin
            h_ref_n    = line_len;
            h_ref_ok_n = 1'b1;
          end else if (len_bad) begin
            line_bad_n = 1'b1;
          end
        end
      end
      ST_CHECK: begin
        if (h_sat) begin
          state_n = ST_SEARCH;
        end else if (boundary) begin
          line_bad_n = 1'b0;
          if (!frame_bad && frame_len == v_ref) begin
            match_n = match_cnt + 4'd1;
            if (match_cnt + 4'd1 == LOCK_N) begin
              state_n   = ST_LOCKED;
              h_total_n = h_ref;
              v_total_n = v_ref;
            end
          end else begin
            state_n    = ST_MEASURE;
            h_ref_ok_n = 1'b0;
          end
        end else if (len_bad) begin
          line_bad_n = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (h_sat || len_bad || (boundary && frame_len != v_ref)) begin
          state_n    = ST_SEARCH;
          sync_err_n = 1'b1;
        end
      end
      default: state_n = ST_SEARCH;
    endcase
  end

  always_ff @(posedge clk_pix or negedge rst) begin
    if (!rst) begin
      state     <= ST_SEARCH;
      h_ref     <= '0;
      h_ref_ok  <= 1'b0;
      v_ref     <= '0;
      line_bad  <= 1'b0;
      match_cnt <= 4'd0;
      h_total   <= '0;
      v_total   <= '0;
      sync_err  <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_n;
      h_ref     <= h_ref_n;
      h_ref_ok  <= h_ref_ok_n;
      v_ref     <= v_ref_n;
      line_bad  <= line_bad_n;
      match_cnt <= match_n;
      h_total   <= h_total_n;
      v_total   <= v_total_n;
      sync_err  <= sync_err_n;
      locked    <= (state_n == ST_LOCKED);
    end
  end

  assign in_win = (h_cnt >= H_FIRST) && (h_cnt < H_END) &&
                  (v_cnt >= V_FIRST) && (v_cnt < V_END);
  // Gating with the next state keeps px_valid from outliving locked.
  assign pv = (state_n == ST_LOCKED) && in_win;

  always_ff @(posedge clk_pix or negedge rst) begin
    if (!rst) begin
      px_valid <= 1'b0;
      px_x     <= '0;
      px_y     <= '0;
      px_rgb   <= 3'b000;
      px_sof   <= 1'b0;
      px_eol   <= 1'b0;
    end else begin
      px_valid <= pv;
      px_x     <= pv ? (h_cnt - H_FIRST) : '0;
      px_y     <= pv ? (v_cnt - V_FIRST) : '0;
      px_rgb   <= pv ? {s2_r, s2_g, s2_b} : 3'b000;
      px_sof   <= pv && (h_cnt == H_FIRST) && (v_cnt == V_FIRST);
      px_eol   <= pv && (h_cnt == H_LAST);
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor on a small 14x7 mode: a driver pushes
// expected pixels into a queue, a negedge monitor pops and compares them.
module tb_vga_sync_monitor;

  localparam int HB = 10;
  localparam int VB = 10;

  logic          clk_pix = 1'b0;
  logic          rst;
  logic          vga_hs, vga_vs, vga_r, vga_g, vga_b;
  logic          locked, px_valid, px_sof, px_eol, sync_err;
  logic [HB-1:0] px_x, h_total;
  logic [VB-1:0] px_y, v_total;
  logic [2:0]    px_rgb;
  logic [1:0]    dbg_state;

  vga_sync_monitor #(
    .H_BITS(HB), .V_BITS(VB), .H_ACTIVE(8), .H_START(4),
    .V_ACTIVE(4), .V_START(2), .HS_POL(1'b0), .VS_POL(1'b0), .LOCK_FRAMES(2)
  ) dut (
    .clk_pix(clk_pix), .rst(rst),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .locked(locked), .px_valid(px_valid), .px_x(px_x), .px_y(px_y),
    .px_rgb(px_rgb), .px_sof(px_sof), .px_eol(px_eol),
    .h_total(h_total), .v_total(v_total), .sync_err(sync_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk_pix = ~clk_pix;

  int cyc = 0;
  always @(posedge clk_pix) cyc <= cyc + 1;

  // scoreboard: {cycle, sof, eol, x, y, rgb}
  logic [56:0] exp_q[$];
  int n_checks = 0, n_errors = 0;
  int pix_cnt = 0, sof_cnt = 0, eol_cnt = 0, sync_pulses = 0, sync_cyc = 0;
  bit sync_prev = 1'b0;
  bit mon_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor
  always @(negedge clk_pix) begin
    if (mon_en) begin
      if (sync_err) begin
        sync_cyc++;
        if (!sync_prev) sync_pulses++;
      end
      sync_prev = sync_err;
      if (px_valid) begin
        logic [56:0] e;
        pix_cnt++;
        sof_cnt += int'(px_sof);
        eol_cnt += int'(px_eol);
        check("px_valid_needs_locked", 64'(locked), 64'd1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL px_unexpected: got pixel x=%0d y=%0d, required none (cycle %0d)",
                   px_x, px_y, cyc);
        end else begin
          e = exp_q.pop_front();
          check("pixel", {7'd0, 32'(cyc), px_sof, px_eol, px_x, px_y, px_rgb}, {7'd0, e});
        end
      end else begin
        check("idle_zero", {39'd0, px_x, px_y, px_sof, px_eol, px_rgb}, 64'd0);
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_pix); #1;
      vga_hs = 1'b1; vga_vs = 1'b1; vga_r = 1'b0; vga_g = 1'b0; vga_b = 1'b0;
    end
  endtask

  task automatic send_line(input int ln, input int len, input bit vs_all, input bit vs_late,
                           input bit push, input bit do_rst);
    for (int p = 0; p < len; p++) begin
      logic [HB-1:0] xv;
      logic [VB-1:0] yv;
      bit act;
      @(posedge clk_pix); #1;
      xv  = HB'(p - 4);
      yv  = VB'(ln - 2);
      act = (p >= 4) && (p < 12) && (ln >= 2) && (ln < 6);
      vga_hs = (p < 2) ? 1'b0 : 1'b1;
      vga_vs = (vs_all || (vs_late && p >= 7)) ? 1'b0 : 1'b1;
      if (act) begin
        vga_r = xv[0]; vga_g = xv[1]; vga_b = yv[0];
      end else begin
        vga_r = 1'($urandom_range(0, 1));
        vga_g = 1'($urandom_range(0, 1));
        vga_b = 1'($urandom_range(0, 1));
      end
      if (push && act)
        exp_q.push_back({32'(cyc + 3), (xv == 0 && yv == 0), (xv == 7), xv, yv,
                         xv[0], xv[1], yv[0]});
      if (do_rst && p == 3) begin
        check("locked_before_rst", 64'(locked), 64'd1);
        rst = 1'b0;
        #2;
        check("rst_locked", 64'(locked), 64'd0);
        check("rst_px_valid", 64'(px_valid), 64'd0);
        check("rst_totals", {44'd0, h_total, v_total}, 64'd0);
        check("rst_sync_err", 64'(sync_err), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
      end
      if (do_rst && p == 9) rst = 1'b1;
    end
  endtask

  task automatic send_frame(input int nl, input int long_ln, input int px_last,
                            input bit early, input int rst_ln, input string nm);
    for (int ln = 0; ln < nl; ln++)
      send_line(ln, (ln == long_ln) ? 15 : 14, ln == 0, early && (ln == nl - 1),
                ln <= px_last, ln == rst_ln);
    check({nm, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    vga_hs = 1'b1; vga_vs = 1'b1; vga_r = 1'b0; vga_g = 1'b0; vga_b = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk_pix);
    #1;
    check("reset_locked", 64'(locked), 64'd0);
    check("reset_outputs", {38'd0, px_valid, px_x, px_y, px_rgb, px_sof, px_eol}, 64'd0);
    check("reset_totals", {44'd0, h_total, v_total}, 64'd0);
    check("reset_sync_err", 64'(sync_err), 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    mon_en = 1'b1;
    rst = 1'b1;
    idle(5);

    // clean acquisition: lock on the 4th boundary (start of frame 3)
    for (int f = 0; f < 3; f++) send_frame(7, -1, -1, 1'b0, -1, "acq");
    check("no_lock_after_3_boundaries", 64'(locked), 64'd0);
    send_frame(7, -1, 6, 1'b0, -1, "f3");
    check("locked_f3", 64'(locked), 64'd1);
    check("h_total", 64'(h_total), 64'd14);
    check("v_total", 64'(v_total), 64'd7);
    send_frame(7, -1, 6, 1'b1, -1, "f4_vs_early");
    send_frame(7, -1, 6, 1'b1, -1, "f5_vs_early");
    check("locked_after_vs_early", 64'(locked), 64'd1);

    // one 15-clock line while locked
    send_frame(7, 3, 3, 1'b0, -1, "f6_glitch");
    check("glitch_sync_err_pulses", 64'(sync_pulses), 64'd1);
    check("glitch_unlocked", 64'(locked), 64'd0);
    for (int f = 0; f < 3; f++) send_frame(7, -1, -1, 1'b0, -1, "relock");
    check("no_relock_yet", 64'(locked), 64'd0);
    send_frame(7, -1, 6, 1'b0, -1, "f10");
    check("relocked_f10", 64'(locked), 64'd1);

    // asynchronous reset in line 1 of a locked frame
    send_frame(7, -1, -1, 1'b0, 1, "f11_rst");
    for (int f = 0; f < 3; f++) send_frame(7, -1, -1, 1'b0, -1, "post_rst");
    check("no_lock_after_rst_3", 64'(locked), 64'd0);
    send_frame(7, -1, 6, 1'b0, -1, "f15");
    check("locked_after_rst", 64'(locked), 64'd1);
    send_frame(7, -1, 6, 1'b0, -1, "f16");

    // hsync stuck inactive: h_cnt timeout
    idle(1100);
    check("timeout_sync_err_pulses", 64'(sync_pulses), 64'd2);
    check("timeout_unlocked", 64'(locked), 64'd0);
    check("timeout_state_search", 64'(dbg_state), 64'd0);

    // 6-line frame while in CHECK
    send_frame(7, -1, -1, 1'b0, -1, "f17");
    send_frame(6, -1, -1, 1'b0, -1, "f18_short");
    check("state_check_f18", 64'(dbg_state), 64'd2);
    send_frame(7, -1, -1, 1'b0, -1, "f19");
    check("state_measure_f19", 64'(dbg_state), 64'd1);
    send_frame(7, -1, -1, 1'b0, -1, "f20");
    send_frame(7, -1, -1, 1'b0, -1, "f21");
    check("no_lock_f21", 64'(locked), 64'd0);
    send_frame(7, -1, 6, 1'b0, -1, "f22");
    check("locked_f22", 64'(locked), 64'd1);
    send_frame(7, -1, 6, 1'b0, -1, "f23");
    idle(20);

    // final report
    check("pixel_total", 64'(pix_cnt), 64'd272);
    check("sof_total", 64'(sof_cnt), 64'd9);
    check("eol_total", 64'(eol_cnt), 64'd34);
    check("sync_err_pulses", 64'(sync_pulses), 64'd2);
    check("sync_err_cycles", 64'(sync_cyc), 64'd2);
    check("queue_empty_end", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_monitor.md
# vga_sync_monitor

Receive-side counterpart of the VGA timing generator. Samples a 1-bit-per-colour VGA stream (hs, vs, r, g, b) on the pixel clock and measures the line and frame timing. Locks onto a stable format and then emits a per-pixel stream with recovered active-area coordinates. Used in loopback benches and on-board self-check to validate generator output against the expected video mode.

## Interface

- H_BITS, 10: width of horizontal counters and `px_x`/`h_total`
- V_BITS, 10: width of vertical counters and `px_y`/`v_total`
- H_ACTIVE, 640: active pixels per line
- H_START, 144: pixel index, relative to hsync leading edge, of first active pixel (sync + back porch)
- V_ACTIVE, 480: active lines per frame
- V_START, 35: line index, relative to the vsync frame boundary, of first active line
- HS_POL, 0 / VS_POL, 0: asserted sync level
- LOCK_FRAMES, 2: consecutive matching frames required to lock (1..15)

Ports:

- clk_pix  in  1  pixel clock; the only clock
- rst  in  1  asynchronous, active-low reset
- vga_hs, vga_vs  in  1 each  sync inputs
- vga_r, vga_g, vga_b  in  1 each  colour inputs
- locked  out  1  format locked
- px_valid  out  1  px_* carry an active pixel
- px_x  out  H_BITS  active column, 0..H_ACTIVE-1
- px_y  out  V_BITS  active row, 0..V_ACTIVE-1
- px_rgb  out  3  {r,g,b} of that pixel
- px_sof  out  1  with px_valid at (0,0)
- px_eol  out  1  with px_valid at x=H_ACTIVE-1
- h_total  out  H_BITS  locked line length in clocks
- v_total  out  V_BITS  locked frame length in lines
- sync_err  out  1  one-cycle pulse on loss of lock

## Operation

- Input stage s1 registers all five inputs. Stage s2 holds the previous s1.
- hs_lead = s1.hs==HS_POL && s2.hs!=HS_POL. vs_lead is defined the same way.
- h_cnt:
  - cleared to 0 on hs_lead, otherwise +1.
  - Saturates at all-ones; saturation means timeout.
- vs_pend is set on vs_lead. A boundary is an hs_lead with vs_pend or vs_lead. A boundary clears vs_pend.
- v_cnt: 0 on a boundary, +1 on other hs_lead, saturating.
- Line length L = h_cnt+1 at hs_lead. Frame length F = v_cnt+1 at a boundary.
- FSM:
  - SEARCH: reset state. At a boundary go to MEASURE and clear line_bad.
  - MEASURE: capture h_ref = L at the first hs_lead; later lines set line_bad if L != h_ref. At a boundary:
    - if !line_bad, h_ref ≥ H_START+H_ACTIVE and F ≥ V_START+V_ACTIVE: v_ref=F, match_cnt=0, go to CHECK.
    - otherwise stay in MEASURE with refs re-armed.
  - CHECK: each hs_lead with L != h_ref sets line_bad. At a boundary:
    - good frame (!line_bad and F==v_ref): match_cnt+1. When it reaches LOCK_FRAMES, go to LOCKED and load h_total=h_ref, v_total=v_ref.
    - bad frame: go to MEASURE.
    - line_bad is cleared at every boundary.
  - LOCKED: any L != h_ref, any boundary with F != v_ref, or h_cnt saturation → SEARCH with a sync_err pulse.
  - h_cnt saturation in any state → SEARCH.
- Pixel output, registered from s2 and the counters:
  - px_valid = LOCKED && H_START ≤ h_cnt < H_START+H_ACTIVE && V_START ≤ v_cnt < V_START+V_ACTIVE.
  - px_x = h_cnt−H_START, px_y = v_cnt−V_START; both 0 when !px_valid.
- locked = (state==LOCKED), registered.

## Timing

- Reset values: every output is 0; state SEARCH; counters, refs and match_cnt are 0.
- Reset is asynchronous, including mid-frame. After release, lock must be reacquired from SEARCH.
- Latency: a pixel sampled into s1 at edge n appears on px_* after edge n+2. hs_lead for that pixel updates h_cnt at edge n+1.
- A sync edge at the pin is seen as a lead event one cycle after sampling.
- The vs leading edge may coincide with or precede the hs leading edge of its line. Both cases produce the same boundary.
- locked rises the cycle after the qualifying boundary and falls the cycle after the failing event. sync_err is high in that same cycle.
- px_valid is never high while !locked. The frame in which lock is acquired outputs pixels from the boundary onward.
- Counter width overflow (line longer than 2^H_BITS−1) is the timeout case, not a wrap.

## Test plan

- Parameters for the small mode: H_ACTIVE=8, H_START=4, line 14 clocks (hs low for 2); V_ACTIVE=4, V_START=2, frame 7 lines (vs low for 1 line).
- Clean stream:
  - locked rises after the 4th boundary; h_total=14, v_total=7.
  - Each following frame has exactly 32 px_valid cycles, x 0..7, y 0..3; px_sof once per frame; px_eol 4 times per frame.
- Pixel data: drive r=x[0], g=x[1], b=y[0] → px_rgb matches (x,y) exactly, 2 cycles after the pin.
- Line glitch: with the stream locked, lengthen one line to 15 clocks → sync_err for one cycle, locked=0, px_valid=0. Relock after 4 further boundaries.
- Frame 6 lines while in CHECK → returns to MEASURE, no lock. Restore 7 lines → lock 3 boundaries later.
- Hold hs inactive for 2^10 clocks while locked → timeout: sync_err pulse, state SEARCH.
- Assert rst mid-frame while locked → all outputs 0 immediately. After release, locked stays 0 until 4 boundaries.
